// File: rtl/alvio_pkg.sv
// alvio_pkg: shared types and default sizing for the ALVIO write queue and
// the other LSU report paths.
//   alvio_rpt_t   one violation report: active-list index plus payload
//   ALVIO_*       default sizing constants
package alvio_pkg;

  localparam int ALVIO_INDEX   = 7;  // active-list index width (ALVIO RAM INDEX)
  localparam int ALVIO_WIDTH   = 1;  // violation payload width (ALVIO RAM WIDTH)
  localparam int ALVIO_NUM_SRC = 2;  // report lanes per cycle
  localparam int ALVIO_QDEPTH  = 8;  // queue entries
  localparam int ALVIO_QINDEX  = 3;  // log2(ALVIO_QDEPTH)

  typedef struct packed {
    logic [ALVIO_INDEX-1:0] alIdx;
    logic [ALVIO_WIDTH-1:0] data;
  } alvio_rpt_t;

endpackage

// File: rtl/alvio_write_queue_if.sv
// alvio_write_queue_if: report and ALVIO-write bundle of the write queue.
//   flush_i      recovery: discard all queued reports
//   vioValid_i   per-lane report valid
//   vioAlIdx_i   per-lane active-list index
//   vioData_i    per-lane payload
//   ready_o      queue can accept a full cycle of reports
//   we0_o        ALVIO write enable
//   addr0wr_o    ALVIO write address
//   data0wr_o    ALVIO write data
//   count_o      current occupancy
// master = report producer side, slave = the queue.
interface alvio_write_queue_if
  import alvio_pkg::*;
#(
  parameter int NUM_SRC = ALVIO_NUM_SRC,
  parameter int QINDEX  = ALVIO_QINDEX
) ();

  logic                                flush_i;
  logic [NUM_SRC-1:0]                  vioValid_i;
  logic [NUM_SRC-1:0][ALVIO_INDEX-1:0] vioAlIdx_i;
  logic [NUM_SRC-1:0][ALVIO_WIDTH-1:0] vioData_i;
  logic                                ready_o;
  logic                                we0_o;
  logic [ALVIO_INDEX-1:0]              addr0wr_o;
  logic [ALVIO_WIDTH-1:0]              data0wr_o;
  logic [QINDEX:0]                     count_o;

  modport master (
    output flush_i, vioValid_i, vioAlIdx_i, vioData_i,
    input  ready_o, we0_o, addr0wr_o, data0wr_o, count_o
  );

  modport slave (
    input  flush_i, vioValid_i, vioAlIdx_i, vioData_i,
    output ready_o, we0_o, addr0wr_o, data0wr_o, count_o
  );

endinterface

// File: rtl/alvio_lane_compact.sv
// alvio_lane_compact: packs the valid report lanes into a dense vector, lane
// order preserved (lowest valid lane lands in slot 0), and counts them.
// Pure combinational.
//   i_valid   per-lane valid
//   i_rpt     per-lane report
//   o_dense   compacted reports, slots 0..o_k-1 meaningful, rest zero
//   o_k       number of valid lanes
module alvio_lane_compact
  import alvio_pkg::*;
#(
  parameter int NUM_SRC = ALVIO_NUM_SRC,
  parameter int KW      = $clog2(NUM_SRC + 1)
) (
  input  logic       [NUM_SRC-1:0] i_valid,
  input  alvio_rpt_t [NUM_SRC-1:0] i_rpt,
  output alvio_rpt_t [NUM_SRC-1:0] o_dense,
  output logic       [KW-1:0]      o_k
);

  localparam int RPT_W = $bits(alvio_rpt_t);

  // Number of valid lanes strictly below 'lane': the slot that lane lands in.
  function automatic int lanes_below(input logic [NUM_SRC-1:0] v, input int lane);
    int n;
    n = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      n = n + (((j < lane) && v[j]) ? 1 : 0);
    end
    return n;
  endfunction

  // Each slot ORs in the one lane whose rank matches it; ranks are unique.
  always_comb begin
    o_dense = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        o_dense[s] = alvio_rpt_t'(o_dense[s] |
                     ({RPT_W{i_valid[i] && (lanes_below(i_valid, i) == s)}} & i_rpt[i]));
      end
    end
  end

  // Popcount of the valid lanes.
  always_comb begin
    o_k = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      o_k = o_k + KW'(i_valid[i]);
    end
  end

endmodule

// File: rtl/alvio_write_queue_chk.sv
// alvio_write_queue_chk: simulation checks on the write queue.
//   i_clk, i_reset   clock and synchronous reset
//   i_count          occupancy
//   i_valid          per-lane report valid
//   i_ready          queue ready
//   i_we0            ALVIO write enable
module alvio_write_queue_chk #(
  parameter int NUM_SRC = 2,
  parameter int QDEPTH  = 8,
  parameter int QINDEX  = 3
) (
  input logic               i_clk,
  input logic               i_reset,
  input logic [QINDEX:0]    i_count,
  input logic [NUM_SRC-1:0] i_valid,
  input logic               i_ready,
  input logic               i_we0
);

  // Occupancy bound, dropped reports, and X on the write enable.
  always_ff @(posedge i_clk) begin
    if (i_reset == 1'b0) begin
      assert (i_count <= (QINDEX+1)'(QDEPTH))
        else $error("alvio_write_queue: occupancy %0d exceeds depth", i_count);
      assert (!((|i_valid) && !i_ready))
        else $error("alvio_write_queue: reports presented while not ready were dropped");
      assert (!$isunknown(i_we0))
        else $error("alvio_write_queue: we0 is unknown");
    end
  end

endmodule

// File: rtl/alvio_write_queue.sv
// alvio_write_queue: collects up to NUM_SRC violation reports per cycle and
// drains them, one per cycle, onto the single ALVIO RAM write port, keeping
// arrival order (by cycle, then lane 0 first).
//   clk     core clock
//   reset   synchronous, active-high
//   io      alvio_write_queue_if.slave: reports in, ALVIO write port and
//           ready/count out
module alvio_write_queue
  import alvio_pkg::*;
#(
  parameter int NUM_SRC = ALVIO_NUM_SRC,
  parameter int QDEPTH  = ALVIO_QDEPTH,
  parameter int QINDEX  = ALVIO_QINDEX
) (
  input logic                clk,
  input logic                reset,
  alvio_write_queue_if.slave io
);

  localparam int              KW          = $clog2(NUM_SRC + 1);
  localparam logic [QINDEX:0] READY_LIMIT = (QINDEX+1)'(QDEPTH - NUM_SRC);

  alvio_rpt_t                r_mem [QDEPTH];
  logic       [QINDEX-1:0]   r_head;
  logic       [QINDEX-1:0]   r_tail;
  logic       [QINDEX:0]     r_count;
  logic                      r_ready;
  logic                      r_we0;

  alvio_rpt_t [NUM_SRC-1:0]  w_lane_rpt;
  alvio_rpt_t [NUM_SRC-1:0]  w_dense;
  logic       [KW-1:0]       w_k;
  logic       [QINDEX:0]     w_add;
  logic       [QINDEX:0]     w_count_next;
  alvio_rpt_t                w_head_rpt;

  // Gather the per-lane bus fields into report structs.
  always_comb begin
    w_lane_rpt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_lane_rpt[i].alIdx = io.vioAlIdx_i[i];
      w_lane_rpt[i].data  = io.vioData_i[i];
    end
  end

  alvio_lane_compact #(
    .NUM_SRC (NUM_SRC),
    .KW      (KW)
  ) u_compact (
    .i_valid (io.vioValid_i),
    .i_rpt   (w_lane_rpt),
    .o_dense (w_dense),
    .o_k     (w_k)
  );

  // Next occupancy: accepted reports in, one out whenever non-empty.
  // r_we0 always equals (r_count != 0).
  always_comb begin
    if (r_ready) begin
      w_add = (QINDEX+1)'(w_k);
    end else begin
      w_add = '0;
    end
    w_count_next = r_count + w_add - (QINDEX+1)'(r_we0);
  end

  // Queue state: reset wins over flush; flush ignores same-cycle reports.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
      r_we0   <= 1'b0;
      for (int e = 0; e < QDEPTH; e++) begin
        r_mem[e] <= '0;
      end
    end else if (io.flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
      r_we0   <= 1'b0;
    end else begin
      if (r_we0) begin
        r_head <= r_head + {{(QINDEX-1){1'b0}}, 1'b1};
      end
      if (r_ready) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (KW'(s) < w_k) begin
            r_mem[r_tail + QINDEX'(s)] <= w_dense[s];
          end
        end
        r_tail <= r_tail + QINDEX'(w_k);
      end
      r_count <= w_count_next;
      r_ready <= (w_count_next <= READY_LIMIT);
      r_we0   <= (w_count_next != '0);
    end
  end

  // Head entry drives the write port; reads zero while the queue is empty.
  always_comb begin
    if (r_we0) begin
      w_head_rpt = r_mem[r_head];
    end else begin
      w_head_rpt = '0;
    end
  end

  assign io.ready_o   = r_ready;
  assign io.we0_o     = r_we0;
  assign io.addr0wr_o = w_head_rpt.alIdx;
  assign io.data0wr_o = w_head_rpt.data;
  assign io.count_o   = r_count;

  alvio_write_queue_chk #(
    .NUM_SRC (NUM_SRC),
    .QDEPTH  (QDEPTH),
    .QINDEX  (QINDEX)
  ) u_chk (
    .i_clk   (clk),
    .i_reset (reset),
    .i_count (r_count),
    .i_valid (io.vioValid_i),
    .i_ready (r_ready),
    .i_we0   (r_we0)
  );

endmodule

// File: tb/tb_alvio_write_queue.sv
// tb_alvio_write_queue: directed bench for alvio_write_queue. Inputs are
// driven 1 time unit after the rising edge, outputs are checked at the same
// point, before new inputs are applied.
module tb_alvio_write_queue;
  import alvio_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  alvio_write_queue_if #(.NUM_SRC(2), .QINDEX(3)) intf ();

  alvio_write_queue #(
    .NUM_SRC (2),
    .QDEPTH  (8),
    .QINDEX  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic [1:0] v, input logic [6:0] i0, input logic d0,
                       input logic [6:0] i1, input logic d1);
    intf.vioValid_i    = v;
    intf.vioAlIdx_i[0] = i0;
    intf.vioData_i[0]  = d0;
    intf.vioAlIdx_i[1] = i1;
    intf.vioData_i[1]  = d1;
  endtask

  initial begin
    int mcount;
    int p;
    int k;
    int exp_next;

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    intf.flush_i = 1'b0;
    drive(2'b00, 7'h00, 1'b0, 7'h00, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b0;

    // T1: idle after reset
    check("t1_addr", intf.addr0wr_o, 32'h0);
    check("t1_data", intf.data0wr_o, 32'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t1_ready", intf.ready_o, 32'h1);
      check("t1_we0",   intf.we0_o,   32'h0);
      check("t1_count", intf.count_o, 32'h0);
    end

    // T2: single report on lane 1
    drive(2'b10, 7'h00, 1'b0, 7'h25, 1'b1);
    tick();
    drive(2'b00, 7'h00, 1'b0, 7'h00, 1'b0);
    check("t2_we0",   intf.we0_o,     32'h1);
    check("t2_addr",  intf.addr0wr_o, 32'h25);
    check("t2_data",  intf.data0wr_o, 32'h1);
    check("t2_count", intf.count_o,   32'h1);
    tick();
    check("t2_we0_after",   intf.we0_o,   32'h0);
    check("t2_count_after", intf.count_o, 32'h0);

    // T3: both lanes whenever ready, 12 pairs through the wrapping buffer
    mcount   = 0;
    p        = 0;
    exp_next = 0;
    for (int cyc = 0; cyc < 100 && !(p == 12 && mcount == 0); cyc++) begin
      check("t3_count", intf.count_o, 32'(mcount));
      check("t3_ready", intf.ready_o, 32'(mcount <= 6));
      check("t3_we0",   intf.we0_o,   32'(mcount != 0));
      if (mcount != 0) begin
        check("t3_addr", intf.addr0wr_o, 32'(exp_next));
        check("t3_data", intf.data0wr_o, 32'(exp_next & 1));
        exp_next++;
      end
      if (mcount <= 6 && p < 12) begin
        drive(2'b11, 7'(2*p), 1'b0, 7'(2*p + 1), 1'b1);
        k = 2;
        p++;
      end else begin
        drive(2'b00, 7'h00, 1'b0, 7'h00, 1'b0);
        k = 0;
      end
      mcount = mcount + k - ((mcount != 0) ? 1 : 0);
      tick();
    end
    check("t3_total_written", 32'(exp_next), 32'd24);
    check("t3_empty", intf.count_o, 32'h0);

    // T4: five queued, flush with two new reports in the same cycle
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 7'h40, 1'b0, 7'h41, 1'b1);
      tick();
      check("t4_fill_count", intf.count_o, 32'(c + 2));
    end
    intf.flush_i = 1'b1;
    drive(2'b11, 7'h50, 1'b1, 7'h51, 1'b1);
    tick();
    intf.flush_i = 1'b0;
    drive(2'b00, 7'h00, 1'b0, 7'h00, 1'b0);
    check("t4_count", intf.count_o,   32'h0);
    check("t4_we0",   intf.we0_o,     32'h0);
    check("t4_ready", intf.ready_o,   32'h1);
    check("t4_addr",  intf.addr0wr_o, 32'h0);
    tick();
    check("t4_count_after", intf.count_o, 32'h0);
    check("t4_we0_after",   intf.we0_o,   32'h0);

    // T5: duplicate index on both lanes
    drive(2'b11, 7'h10, 1'b0, 7'h10, 1'b1);
    tick();
    drive(2'b00, 7'h00, 1'b0, 7'h00, 1'b0);
    check("t5_we0_a",   intf.we0_o,     32'h1);
    check("t5_addr_a",  intf.addr0wr_o, 32'h10);
    check("t5_data_a",  intf.data0wr_o, 32'h0);
    check("t5_count_a", intf.count_o,   32'h2);
    tick();
    check("t5_we0_b",   intf.we0_o,     32'h1);
    check("t5_addr_b",  intf.addr0wr_o, 32'h10);
    check("t5_data_b",  intf.data0wr_o, 32'h1);
    check("t5_count_b", intf.count_o,   32'h1);
    tick();
    check("t5_we0_end",   intf.we0_o,   32'h0);
    check("t5_count_end", intf.count_o, 32'h0);

    // T6: reset while holding six entries, then resume
    for (int c = 0; c < 5; c++) begin
      drive(2'b11, 7'h60, 1'b0, 7'h61, 1'b1);
      tick();
    end
    drive(2'b00, 7'h00, 1'b0, 7'h00, 1'b0);
    check("t6_count_full", intf.count_o, 32'h6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_count", intf.count_o, 32'h0);
    check("t6_we0",   intf.we0_o,   32'h0);
    check("t6_ready", intf.ready_o, 32'h1);
    drive(2'b01, 7'h33, 1'b1, 7'h00, 1'b0);
    tick();
    drive(2'b00, 7'h00, 1'b0, 7'h00, 1'b0);
    check("t6_resume_we0",   intf.we0_o,     32'h1);
    check("t6_resume_addr",  intf.addr0wr_o, 32'h33);
    check("t6_resume_data",  intf.data0wr_o, 32'h1);
    check("t6_resume_count", intf.count_o,   32'h1);
    tick();
    check("t6_resume_empty", intf.count_o, 32'h0);
    check("t6_resume_idle",  intf.we0_o,   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
